// File: rtl/vme_master_pkg.sv
// vme_master_pkg
// Shared definitions for the VME-style register bus initiator.
//   state_t      : initiator FSM states (IDLE, STROBE, WAIT, RESP)
//   DEF_ADDR_W   : default bus address width
//   DEF_DATA_W   : default bus data width
//   DEF_TIMEOUT  : default Done timeout in WAIT cycles
//   CNT_W        : width of the timeout counter
package vme_master_pkg;

    localparam int DEF_ADDR_W  = 16;
    localparam int DEF_DATA_W  = 32;
    localparam int DEF_TIMEOUT = 255;
    localparam int CNT_W       = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STROBE = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } state_t;

endpackage

// File: rtl/vme_timeout_cnt.sv
// vme_timeout_cnt
// Counts WAIT cycles for the initiator and flags expiry.
// Only instantiated when VME_MASTER_TIMEOUT_EN is defined.
// Ports:
//   clk     in  1      clock, rising edge
//   rst_n   in  1      synchronous active-low reset
//   clear   in  1      restart the count from zero
//   enable  in  1      count this cycle
//   limit   in  CNT_W  number of enabled cycles until expiry
//   expired out 1      this enabled cycle is the limit-th one
import vme_master_pkg::*;

module vme_timeout_cnt (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             enable,
    input  logic [CNT_W-1:0] limit,
    output logic             expired
);

    logic [CNT_W-1:0] cnt;

    // Expiry is flagged in the cycle whose increment would make the count
    // equal the limit, so the FSM leaves WAIT after exactly 'limit' cycles.
    assign expired = enable && ((cnt + 1'b1) == limit);

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            cnt <= '0;
        end else if (enable && !expired) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/vme_reg_master.sv
// vme_reg_master
// Bus initiator for the VME-style register-block strobe/done interface.
// Takes single read/write commands on a valid/ready port, issues a one-cycle
// VMERdMem/VMEWrMem strobe, waits for the matching Done and returns the
// result on a valid/ready response port.
// Optional feature macro: VME_MASTER_TIMEOUT_EN (Done timeout, rsp_err=1).
// Ports:
//   Clk, rst_n                      clock, synchronous active-low reset
//   cmd_valid/ready/write/addr/wdata   command port
//   rsp_valid/ready/rdata/err          response port
//   busy                            FSM not in IDLE
//   VMEAddr, VMEWrData, VMERdMem, VMEWrMem   bus request side
//   VMERdData, VMERdDone, VMEWrDone          bus completion side
import vme_master_pkg::*;

module vme_reg_master #(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic              Clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              busy,
    output logic [ADDR_W-1:0] VMEAddr,
    output logic [DATA_W-1:0] VMEWrData,
    output logic              VMERdMem,
    output logic              VMEWrMem,
    input  logic [DATA_W-1:0] VMERdData,
    input  logic              VMERdDone,
    input  logic              VMEWrDone
);

    state_t state_q;
    state_t state_d;
    logic   wr_q;
    logic   done_match;
    logic   timeout_hit;

    // Only the Done belonging to the outstanding access may complete it.
    assign done_match = wr_q ? VMEWrDone : VMERdDone;

`ifdef VME_MASTER_TIMEOUT_EN
    vme_timeout_cnt u_timeout_cnt (
        .clk     (Clk),
        .rst_n   (rst_n),
        .clear   (state_q == STROBE),
        .enable  (state_q == WAIT),
        .limit   (CNT_W'(TIMEOUT)),
        .expired (timeout_hit)
    );
`else
    assign timeout_hit = 1'b0;
`endif

    assign busy      = (state_q != IDLE);
    assign rsp_valid = (state_q == RESP);

    always_ff @(posedge Clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // cmd_ready is gated with rst_n so nothing is offered while reset is held.
    // A Done coinciding with timeout expiry still counts as a normal completion.
    always_comb begin
        state_d   = state_q;
        cmd_ready = 1'b0;
        VMERdMem  = 1'b0;
        VMEWrMem  = 1'b0;
        case (state_q)
            IDLE: begin
                cmd_ready = rst_n;
                if (cmd_valid) begin
                    state_d = STROBE;
                end
            end
            STROBE: begin
                VMEWrMem = wr_q;
                VMERdMem = ~wr_q;
                state_d  = WAIT;
            end
            WAIT: begin
                if (done_match || timeout_hit) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Request fields are captured on accept and held until the next accept,
    // which keeps them stable from STROBE through RESP.
    always_ff @(posedge Clk) begin
        if (!rst_n) begin
            wr_q      <= 1'b0;
            VMEAddr   <= '0;
            VMEWrData <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cmd_valid) begin
                        wr_q      <= cmd_write;
                        VMEAddr   <= cmd_addr;
                        VMEWrData <= cmd_wdata;
                        rsp_rdata <= '0;
                        rsp_err   <= 1'b0;
                    end
                end
                WAIT: begin
                    if (done_match) begin
                        if (!wr_q) begin
                            rsp_rdata <= VMERdData;
                        end
                    end else if (timeout_hit) begin
                        rsp_err <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
